// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and the byte value that releases the line lock.
package uart_tx_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_HOLD  = 3'd4
   } tx_state_e;

   localparam logic [7:0]  NEWLINE   = 8'h0a;
   localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_shifter.sv
// 8N1 serialiser: baud counter, bit counter and shift register. A load starts
// the start bit on the next cycle; tick_o marks the last cycle of every bit.
module uart_tx_shifter
   import uart_tx_sched_pkg::*;
#(
   parameter int unsigned CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       resetb,
   input  logic       load_i,
   input  logic       run_i,
   input  logic [7:0] data_i,
   output logic       tick_o,
   output logic [3:0] bit_cnt_o,
   output logic       ser_o
);

   localparam int unsigned   BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          ser_q, ser_d;

   assign tick_o    = run_i && (baud_q == BAUD_LAST);
   assign bit_cnt_o = bit_q;
   assign ser_o     = ser_q;

   // Next-state: shifting in ones means the stop level falls out after the data bits.
   always_comb begin
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      ser_d   = ser_q;
      if (load_i) begin
         baud_d  = '0;
         bit_d   = 4'd0;
         shift_d = data_i;
         ser_d   = 1'b0;
      end else if (run_i) begin
         if (baud_q == BAUD_LAST) begin
            baud_d  = '0;
            bit_d   = bit_q + 4'd1;
            ser_d   = shift_q[0];
            shift_d = {1'b1, shift_q[7:1]};
         end else begin
            baud_d = baud_q + BW'(1);
         end
      end else begin
         baud_d = baud_q;
      end
   end

   // State registers; the line idles high out of reset.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         baud_q  <= '0;
         bit_q   <= 4'd0;
         shift_q <= 8'h00;
         ser_q   <= 1'b1;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         ser_q   <= ser_d;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte arbiter with a per-owner line lock feeding one UART
// transmitter. The lock is released by a newline byte or an idle timeout.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned CLK_DIV  = 16,
   parameter int unsigned HOLD_TMO = 4096
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              enable,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic              ser_tx,
   output logic              busy,
   output logic [1:0]        owner
);

   localparam int unsigned   TW       = $clog2(HOLD_TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(HOLD_TMO - 1);

   tx_state_e       state_q, state_d;
   logic [1:0]      owner_q, owner_d;
   logic [7:0]      byte_q, byte_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            busy_q;

   logic [NREQ-1:0] grant_oh_s, owner_oh_s, ready_s;
   logic [7:0]      grant_byte_s, own_byte_s;
   logic [1:0]      grant_idx_s;
   logic            grant_ok_s, own_valid_s, load_s, run_s, tick_s;
   logic [3:0]      bit_cnt_s;
   int              best_s, dist_s;

   // Round-robin pick: smallest distance after the last owner wins.
   always_comb begin
      best_s       = int'(NREQ);
      dist_s       = 0;
      grant_idx_s  = owner_q;
      grant_byte_s = 8'h00;
      grant_oh_s   = '0;
      owner_oh_s   = '0;
      own_byte_s   = 8'h00;
      for (int j = 0; j < int'(NREQ); j++) begin
         dist_s = j + int'(NREQ) - int'(owner_q) - 1;
         if (dist_s >= int'(NREQ)) begin
            dist_s = dist_s - int'(NREQ);
         end else begin
            dist_s = dist_s;
         end
         if (req_valid[j] && (dist_s < best_s)) begin
            best_s       = dist_s;
            grant_idx_s  = 2'(j);
            grant_byte_s = req_data[8*j +: 8];
         end else begin
            best_s = best_s;
         end
         owner_oh_s[j] = (owner_q == 2'(j));
         if (owner_oh_s[j]) begin
            own_byte_s = req_data[8*j +: 8];
         end else begin
            own_byte_s = own_byte_s;
         end
      end
      grant_ok_s  = (best_s < int'(NREQ));
      for (int j = 0; j < int'(NREQ); j++) begin
         grant_oh_s[j] = grant_ok_s && (grant_idx_s == 2'(j));
      end
      own_valid_s = |(req_valid & owner_oh_s);
   end

   // Lock FSM next-state; HOLD serves only the owner and ignores enable.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      byte_d  = byte_q;
      tmo_d   = tmo_q;
      ready_s = '0;
      load_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && grant_ok_s) begin
               ready_s = grant_oh_s;
               owner_d = grant_idx_s;
               byte_d  = grant_byte_s;
               load_s  = 1'b1;
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) state_d = ST_DATA;
            else        state_d = ST_START;
         end
         ST_DATA: begin
            if (tick_s && (bit_cnt_s == 4'(DATA_BITS))) state_d = ST_STOP;
            else                                        state_d = ST_DATA;
         end
         ST_STOP: begin
            if (tick_s) begin
               tmo_d   = '0;
               state_d = (byte_q == NEWLINE) ? ST_IDLE : ST_HOLD;
            end else begin
               state_d = ST_STOP;
            end
         end
         ST_HOLD: begin
            if (own_valid_s) begin
               ready_s = owner_oh_s;
               byte_d  = own_byte_s;
               load_s  = 1'b1;
               tmo_d   = '0;
               state_d = ST_START;
            end else if (tmo_q == TMO_LAST) begin
               tmo_d   = '0;
               state_d = ST_IDLE;
            end else begin
               tmo_d   = tmo_q + TW'(1);
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign run_s     = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
   assign req_ready = ready_s & {NREQ{resetb}};
   assign busy      = busy_q;
   assign owner     = owner_q;

   // State registers; owner resets to the last index so the first grant goes to 0.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q <= ST_IDLE;
         owner_q <= 2'(NREQ - 1);
         byte_q  <= 8'h00;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         byte_q  <= byte_d;
         tmo_q   <= tmo_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   uart_tx_shifter #(
      .CLK_DIV (CLK_DIV)
   ) u_shifter (
      .clk       (clk),
      .resetb    (resetb),
      .load_i    (load_s),
      .run_i     (run_s),
      .data_i    (byte_d),
      .tick_o    (tick_s),
      .bit_cnt_o (bit_cnt_s),
      .ser_o     (ser_tx)
   );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: requester queues drive the DUT, a
// receiver decodes ser_tx and scoreboards bytes and grant order.
module tb_uart_tx_sched;

   logic       clk;
   logic       resetb;
   logic       enable;
   logic [1:0] req_valid;
   logic [15:0] req_data;
   logic [1:0] req_ready;
   logic       ser_tx;
   logic       busy;
   logic [1:0] owner;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rq0[$];
   logic [7:0] rq1[$];
   logic [7:0] exp_byte_q[$];
   int         exp_grant_q[$];
   logic [1:0] pend;
   logic       owner_chk;
   int         owner_exp;
   logic       rx_act;
   int         rx_cnt;
   logic [7:0] rx_byte;

   uart_tx_sched #(
      .NREQ     (2),
      .CLK_DIV  (4),
      .HOLD_TMO (32)
   ) dut (
      .clk       (clk),
      .resetb    (resetb),
      .enable    (enable),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .ser_tx    (ser_tx),
      .busy      (busy),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Requester model: pop accepted bytes and present the queue heads.
   always @(posedge clk) begin
      #1;
      if (pend[0]) begin
         if (rq0.size() != 0) void'(rq0.pop_front());
         pend[0] = 1'b0;
      end
      if (pend[1]) begin
         if (rq1.size() != 0) void'(rq1.pop_front());
         pend[1] = 1'b0;
      end
      req_valid[0]   = (rq0.size() != 0);
      req_data[7:0]  = (rq0.size() != 0) ? rq0[0] : 8'h00;
      req_valid[1]   = (rq1.size() != 0);
      req_data[15:8] = (rq1.size() != 0) ? rq1[0] : 8'h00;
   end

   // Grant monitor: one-hot strobe, grant order, owner follow-up.
   always @(negedge clk) begin
      if (owner_chk) begin
         check_eq("owner", 32'(owner), 32'(owner_exp));
         owner_chk = 1'b0;
      end
      check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      if (resetb) begin
         for (int i = 0; i < 2; i++) begin
            if (req_ready[i] && req_valid[i]) begin
               if (exp_grant_q.size() == 0) check_eq("grant_unexp", 32'(i), 32'hff);
               else check_eq("grant_idx", 32'(i), 32'(exp_grant_q.pop_front()));
               owner_chk = 1'b1;
               owner_exp = i;
               pend[i]   = 1'b1;
            end
         end
      end
   end

   // Receiver: mid-bit sampling from the first low cycle of the start bit.
   always @(negedge clk) begin
      if (!resetb) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (ser_tx == 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == 2) check_eq("rx_start", 32'(ser_tx), 32'd0);
         if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
            rx_byte[(rx_cnt - 6) / 4] = ser_tx;
         if (rx_cnt == 38) begin
            check_eq("rx_stop", 32'(ser_tx), 32'd1);
            if (exp_byte_q.size() == 0) check_eq("rx_unexp", 32'(rx_byte), 32'h1ff);
            else check_eq("rx_byte", 32'(rx_byte), 32'(exp_byte_q.pop_front()));
            rx_act = 1'b0;
         end
      end
   end

   task automatic apply_reset();
      resetb = 1'b0;
      rq0.delete();
      rq1.delete();
      exp_byte_q.delete();
      exp_grant_q.delete();
      pend      = 2'b00;
      owner_chk = 1'b0;
      req_valid = 2'b00;
      req_data  = 16'h0000;
      repeat (3) @(posedge clk);
      #1 resetb = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_ready(input int idx);
      int n = 0;
      while (!req_ready[idx] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("ready_seen", 32'(n < 100), 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_byte_q.size() != 0 || busy) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_done", 32'(n < 600), 32'd1);
      check_eq("grants_left", 32'(exp_grant_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      resetb    = 1'b1;
      enable    = 1'b1;
      req_valid = 2'b00;
      req_data  = 16'h0000;
      pend      = 2'b00;
      owner_chk = 1'b0;
      rx_act    = 1'b0;
      rx_cnt    = 0;
      rx_byte   = 8'h00;
      #1 resetb = 1'b0;
      #1;
      check_eq("rst_ser", 32'(ser_tx), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_ready", 32'(req_ready), 32'd0);
      check_eq("rst_owner", 32'(owner), 32'd1);
      apply_reset();

      // Single 0x41 frame, then HOLD until timeout.
      rq0.push_back(8'h41);
      exp_byte_q.push_back(8'h41);
      exp_grant_q.push_back(0);
      wait_ready(0);
      check_eq("acc_ser", 32'(ser_tx), 32'd1);
      check_eq("acc_busy", 32'(busy), 32'd0);
      for (int k = 1; k <= 73; k++) begin
         @(negedge clk);
         if (k == 1) check_eq("ready_1cyc", 32'(req_ready), 32'd0);
         if (k == 1 || k == 4) check_eq("start_low", 32'(ser_tx), 32'd0);
         if (k == 5) check_eq("bit0", 32'(ser_tx), 32'd1);
         if (k == 1 || k == 40 || k == 41 || k == 72) check_eq("busy_hi", 32'(busy), 32'd1);
         if (k == 37 || k == 40) check_eq("stop_hi", 32'(ser_tx), 32'd1);
         if (k == 73) check_eq("busy_lo", 32'(busy), 32'd0);
      end
      wait_drain();
      apply_reset();

      // "AB\n" from req0 while req1 waits with 0x5a.
      rq0.push_back(8'h41); rq0.push_back(8'h42); rq0.push_back(8'h0a);
      rq1.push_back(8'h5a);
      exp_byte_q.push_back(8'h41); exp_byte_q.push_back(8'h42);
      exp_byte_q.push_back(8'h0a); exp_byte_q.push_back(8'h5a);
      exp_grant_q.push_back(0); exp_grant_q.push_back(0);
      exp_grant_q.push_back(0); exp_grant_q.push_back(1);
      wait_drain();
      apply_reset();

      // Newline bytes release the lock each time: grants alternate.
      for (int k = 0; k < 2; k++) begin
         rq0.push_back(8'h0a);
         rq1.push_back(8'h0a);
         exp_grant_q.push_back(0);
         exp_grant_q.push_back(1);
         exp_byte_q.push_back(8'h0a);
         exp_byte_q.push_back(8'h0a);
      end
      wait_drain();
      apply_reset();

      // Lock timeout hands the line to req1.
      rq0.push_back(8'h41);
      rq1.push_back(8'h0a);
      exp_byte_q.push_back(8'h41); exp_byte_q.push_back(8'h0a);
      exp_grant_q.push_back(0); exp_grant_q.push_back(1);
      wait_ready(0);
      n = 0;
      while (!req_ready[1] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("tmo_grant_cyc", 32'(n), 32'd73);
      wait_drain();
      apply_reset();

      // Reset in the middle of a frame.
      rq0.push_back(8'h00); rq0.push_back(8'h0a);
      exp_byte_q.push_back(8'h00);
      exp_grant_q.push_back(0);
      wait_ready(0);
      repeat (15) @(negedge clk);
      check_eq("pre_rst_ser", 32'(ser_tx), 32'd0);
      #1 resetb = 1'b0;
      #1;
      check_eq("mid_rst_ser", 32'(ser_tx), 32'd1);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_eq("rst_no_ready", 32'(req_ready), 32'd0);
      end
      apply_reset();

      // Enable low blocks grants; raising it grants req0 on the next edge.
      enable = 1'b0;
      rq0.push_back(8'h0a);
      rq1.push_back(8'h0a);
      exp_byte_q.push_back(8'h0a); exp_byte_q.push_back(8'h0a);
      exp_grant_q.push_back(0); exp_grant_q.push_back(1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k > 1) begin
            check_eq("dis_ready", 32'(req_ready), 32'd0);
            check_eq("dis_ser", 32'(ser_tx), 32'd1);
         end
      end
      @(posedge clk);
      #1 enable = 1'b1;
      @(negedge clk);
      check_eq("en_grant", 32'(req_ready), 32'd1);
      wait_drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 2: number of byte requesters; legal range 2..4.
REQ-002 Parameter CLK_DIV, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-003 Parameter HOLD_TMO, default 4096: clk cycles a locked owner may stay idle before losing the line.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 resetb  input  1: asynchronous, active-low reset.
REQ-006 enable  input  1: when low, no new grant is issued; a frame already in flight completes.
REQ-007 req_valid  input  NREQ: per-requester byte-available flag.
REQ-008 req_data  input  8*NREQ: byte i occupies bits [8i+7:8i].
REQ-009 req_ready  output  NREQ: one-hot accept strobe; a byte transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 ser_tx  output  1: serial line, 8N1, LSB first, idle high.
REQ-011 busy  output  1: high in every state except IDLE.
REQ-012 owner  output  2: index of the current or last granted requester.

Function
REQ-013 FSM states: IDLE, START, DATA, STOP, HOLD.
REQ-014 IDLE with enable high and any req_valid: grant round-robin, searching from (last owner + 1) mod NREQ; pulse that req_ready for 1 cycle; latch the byte; go to START.
REQ-015 req_ready is combinational from state and req_valid, so acceptance takes exactly 1 cycle.
REQ-016 START: ser_tx = 0 for CLK_DIV cycles, beginning the cycle after acceptance.
REQ-017 DATA: 8 bits, bit 0 first, each held CLK_DIV cycles.
REQ-018 STOP: ser_tx = 1 for CLK_DIV cycles, then leave STOP.
REQ-019 A frame lasts exactly 10*CLK_DIV cycles.
REQ-020 After STOP with latched byte = 8'h0a: go to IDLE and release the lock; the next arbitration starts after this owner.
REQ-021 After STOP with any other byte: go to HOLD; the owner keeps the line.
REQ-022 HOLD with req_valid[owner] high: accept from the owner only (pulse req_ready[owner]), go to START, clear the timeout counter. enable does not gate HOLD.
REQ-023 HOLD with req_valid[owner] low: increment the timeout counter; at HOLD_TMO go to IDLE and release the lock.
REQ-024 Other requesters' req_valid are ignored in START, DATA, STOP and HOLD.
REQ-025 A requester deasserting valid mid-frame has no effect; its byte was latched at acceptance.
REQ-026 Bit counter and baud counter are sized to fit CLK_DIV and 8 bits; no wrap occurs inside a bit period.
REQ-027 At most one req_ready bit is high in any cycle.

Reset
REQ-028 On resetb low, asynchronously: state = IDLE, ser_tx = 1, req_ready = 0, busy = 0, owner = NREQ-1 (first grant goes to 0), all counters = 0, latched byte = 0.
REQ-029 Reset asserted mid-frame forces ser_tx high immediately; the partial frame is abandoned with no further strobes.

Structure
REQ-030 A shared package holds the state encoding and the newline constant 8'h0a.
REQ-031 One sub-module, uart_tx_shifter, contains the baud counter, the bit counter and the shift register; the arbiter and lock FSM live in uart_tx_sched.

Verification (NREQ=2, CLK_DIV=4, HOLD_TMO=32; a receiver model decodes ser_tx)
REQ-032 Req0 sends 8'h41 -> req_ready[0] high 1 cycle; ser_tx low 4 cycles starting next cycle; bits 1,0,0,0,0,0,1,0; stop high; busy high 40 cycles, then HOLD.
REQ-033 Req0 sends "AB\n" while req1 holds valid with 8'h5a -> receiver gets 41,42,0a, then 5a; req_ready[1] never pulses before 0a completes.
REQ-034 Both idle-valid after reset with lock cleared each time (bytes 0a) -> grants alternate 0,1,0,1; owner output tracks each grant.
REQ-035 Req0 sends 8'h41 then stops; req1 valid -> req1 granted exactly 32 cycles after HOLD entry.
REQ-036 resetb pulsed low at cycle 15 of a frame -> ser_tx = 1 and busy = 0 in the same cycle; no req_ready pulses until resetb is released.
REQ-037 enable low with both valid -> no req_ready, ser_tx stays 1; raising enable grants req0 on the next edge.
